// File: rtl/display_arbiter.sv
// display_arbiter
//
// Shares one numeric display between N_SRC value producers. Valid sources
// are shown in round-robin order, each for DWELL cycles. A source that is
// both valid and urgent pre-empts rotation, with the lowest index winning.
// When no urgent source remains, rotation resumes from the source that
// owned the display before the urgent episode.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   rst_n         synchronous active-low reset
//   src_valid     bit i: source i wants display time
//   src_urgent    bit i: source i requests pre-emption (only with src_valid[i])
//   src_value     flattened source values, source i at [i*DATA_W +: DATA_W]
//   value         registered value of the current owner (0 while blank)
//   owner         index of the current owner
//   owner_onehot  one-hot form of owner, all zero while blank
//   blank         high when no source is valid (IDLE)
//   switched      one-cycle pulse when owner moves to a different source
module display_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    parameter int DWELL  = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC-1:0]           src_urgent,
    input  logic [N_SRC*DATA_W-1:0]    src_value,
    output logic [DATA_W-1:0]          value,
    output logic [$clog2(N_SRC)-1:0]   owner,
    output logic [N_SRC-1:0]           owner_onehot,
    output logic                       blank,
    output logic                       switched
);

    localparam int OW = $clog2(N_SRC);
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROTATE,
        S_URGENT
    } state_t;

    // First set bit of v scanning circularly from start (inclusive).
    // Result is {found, index}.
    function automatic logic [OW:0] scan_from(input logic [N_SRC-1:0] v,
                                              input int start);
        logic          found;
        logic [OW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            int j;
            j = (start + k) % N_SRC;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = OW'(j);
            end
        end
        return {found, idx};
    endfunction

    // Lowest set bit of v (fixed priority). Result is {found, index}.
    function automatic logic [OW:0] lowest_set(input logic [N_SRC-1:0] v);
        logic          found;
        logic [OW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (v[k]) begin
                found = 1'b1;
                idx   = OW'(k);
            end
        end
        return {found, idx};
    endfunction

    state_t              state_reg, state_next;
    logic [OW-1:0]       owner_reg, owner_next;
    logic [OW-1:0]       saved_owner_reg, saved_owner_next;
    logic [CW-1:0]       dwell_reg, dwell_next;
    logic [DATA_W-1:0]   value_reg, value_next;
    logic [N_SRC-1:0]    onehot_reg, onehot_next;
    logic                blank_reg, blank_next;
    logic                switched_reg, switched_next;

    logic [DATA_W-1:0]   src_arr [N_SRC];
    logic [N_SRC-1:0]    urg_vec;
    logic                urg_found, resume_found, step_found;
    logic [OW-1:0]       urg_idx, resume_idx, step_idx;
    logic                step_due;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_arr[gi]     = src_value[gi*DATA_W +: DATA_W];
            assign onehot_next[gi] = (state_next != S_IDLE) && (owner_next == OW'(gi));
        end
    endgenerate

    assign urg_vec = src_valid & src_urgent;
    assign {urg_found, urg_idx}       = lowest_set(urg_vec);
    // Resume point after IDLE/URGENT: saved owner itself is eligible.
    assign {resume_found, resume_idx} = scan_from(src_valid, int'(saved_owner_reg));
    // Rotation step: start after the owner; the owner is reached last, so a
    // lone valid owner is simply kept.
    assign {step_found, step_idx}     = scan_from(src_valid, int'(owner_reg) + 1);
    // Dwell expiry and owner drop in the same cycle collapse into one step.
    assign step_due = (dwell_reg == DWELL_LAST) || !src_valid[owner_reg];

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        saved_owner_next = saved_owner_reg;
        dwell_next       = dwell_reg;

        case (state_reg)
            S_IDLE: begin
                dwell_next = '0;
                if (urg_found) begin
                    state_next = S_URGENT;
                    owner_next = urg_idx;
                end else if (resume_found) begin
                    state_next = S_ROTATE;
                    owner_next = resume_idx;
                end
            end

            S_ROTATE: begin
                // Pre-emption outranks a rotation step in the same cycle.
                if (urg_found) begin
                    saved_owner_next = owner_reg;
                    state_next       = S_URGENT;
                    owner_next       = urg_idx;
                    dwell_next       = '0;
                end else if (step_due) begin
                    dwell_next = '0;
                    if (step_found) begin
                        owner_next = step_idx;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    dwell_next = dwell_reg + CW'(1);
                end
            end

            S_URGENT: begin
                dwell_next = '0;
                if (urg_found) begin
                    owner_next = urg_idx;
                end else if (resume_found) begin
                    state_next = S_ROTATE;
                    owner_next = resume_idx;
                end else begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                dwell_next = '0;
            end
        endcase
    end

    assign blank_next    = (state_next == S_IDLE);
    assign value_next    = blank_next ? '0 : src_arr[owner_next];
    assign switched_next = !blank_next && (owner_next != owner_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            owner_reg       <= '0;
            saved_owner_reg <= '0;
            dwell_reg       <= '0;
            value_reg       <= '0;
            onehot_reg      <= '0;
            blank_reg       <= 1'b1;
            switched_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            saved_owner_reg <= saved_owner_next;
            dwell_reg       <= dwell_next;
            value_reg       <= value_next;
            onehot_reg      <= onehot_next;
            blank_reg       <= blank_next;
            switched_reg    <= switched_next;
        end
    end

    assign value        = value_reg;
    assign owner        = owner_reg;
    assign owner_onehot = onehot_reg;
    assign blank        = blank_reg;
    assign switched     = switched_reg;

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit numeric display between up to `N_SRC` value producers, such as a free-running count, switch readback, or error codes. Valid sources are shown in round-robin order, each for a fixed dwell time. A source raising `urgent` pre-empts rotation immediately. The block sits between the producers and the `value` input of the display driver, and also drives LEDs that indicate which source currently owns the display.

## Interface

- `N_SRC`, default 4: number of requesters; 2..8.
- `DATA_W`, default 16: width of each source value; matches the display driver's `value`.
- `DWELL`, default 50_000_000: cycles each source is shown during rotation; must be ≥ 2.
- `clk`, in, 1: single system clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `src_valid`, in, `N_SRC`: bit i high means source i wants display time.
- `src_urgent`, in, `N_SRC`: bit i high means source i requests pre-emption. Ignored unless `src_valid[i]` is also high.
- `src_value`, in, `N_SRC*DATA_W`: flattened values; source i occupies bits `[i*DATA_W +: DATA_W]`.
- `value`, out, `DATA_W`: registered value of the current owner, fed to the display driver.
- `owner`, out, `clog2(N_SRC)`: index of the current owner.
- `owner_onehot`, out, `N_SRC`: one-hot form of `owner`. All zero when blank.
- `blank`, out, 1: high when no source is valid.
- `switched`, out, 1: one-cycle pulse in the cycle `owner` changes to a different source.

## Operation

**States.** IDLE, ROTATE, URGENT. The dwell counter is `clog2(DWELL)` bits wide. `saved_owner` is a register used to resume rotation after an urgent episode.

**Reset** (`rst_n` low at a clock edge, including mid-operation):
- State goes to IDLE.
- `owner`, `saved_owner`, and the dwell counter go to 0.
- `value` goes to 0.
- `blank` goes to 1.
- `owner_onehot` goes to 0.
- `switched` goes to 0.

**IDLE:**
- Holds `blank`=1 and `value`=0.
- If any `src_valid & src_urgent` bit is set, go to URGENT.
- Otherwise, if any `src_valid` bit is set, go to ROTATE. Owner becomes the first valid index found by scanning circularly from `saved_owner`, inclusive. Dwell resets to 0.

**ROTATE:**
- The dwell counter increments every cycle.
- A rotation step is triggered when dwell reaches `DWELL-1` or when `src_valid[owner]` drops.
- On a rotation step:
  - Owner becomes the next valid index after `owner`, scanning circularly from `owner+1`.
  - If the current owner is the only valid source, it is kept and only dwell restarts.
  - If no source is valid, go to IDLE and keep `owner`.
  - Dwell restarts at 0.
- Pre-emption: any `src_valid & src_urgent` bit set means `saved_owner <= owner` and go to URGENT. This check is evaluated before the rotation step in the same cycle.

**URGENT:**
- Owner is the lowest index with `src_valid & src_urgent` set (fixed priority). It is re-evaluated every cycle, so a lower index appearing takes over on the next edge.
- The dwell counter is held at 0.
- When no urgent+valid source remains:
  - Go to ROTATE. Owner is the first valid index scanning circularly from `saved_owner`, inclusive. Dwell starts at 0.
  - If no source is valid, go to IDLE instead.

**Outputs:**
- `value` is `src_value` of the next-state owner, registered every cycle, so live changes from the owner track with 1 cycle of lag.
- `blank`=1 exactly when the next state is IDLE.
- `switched` pulses only when the owner index differs from the previous cycle and the next state is not IDLE.

## Timing

- All decisions are made from inputs sampled at edge k. `owner`, `value`, `blank`, and `switched` update together at edge k.
- Input-to-output latency is 1 cycle.
- A source is shown for exactly `DWELL` cycles when it is uninterrupted and other sources are valid.
- Wrap-around: after index `N_SRC-1`, the scan continues at 0.
- Simultaneous drop of the owner's valid and a dwell expiry count as one rotation step, not two.
- Urgent asserted together with `src_valid`=0 for that bit is ignored.
- Reset has priority over every other event.

## Test plan

- **Reset and idle:** with `rst_n`=0 for 2 cycles and all inputs 0, `value`=0, `blank`=1, `owner`=0, and `switched`=0. These must hold while idle.
- **Rotation:** with `DWELL`=4, `src_valid`=4'b1011, and values 0x1111/0x2222/0x3333/0x4444, the owner sequence is 0,1,3,0, each held exactly 4 cycles. `switched` pulses at each change.
- **Early rotation:** drop `src_valid[1]` while source 1 has been owner for 1 cycle. The next edge gives `owner`=3, and the dwell restarts.
- **Pre-emption:** during rotation with source 0 as owner, assert `src_urgent`=4'b1010 with all valid. The next edge gives `owner`=1 and holds it. Clearing `src_urgent` resumes with `owner`=0 and a full dwell.
- **All sources drop:** drop all `src_valid` mid-dwell. The next edge gives `blank`=1 and `value`=0. Re-asserting `src_valid[2]` only gives `owner`=2 and `blank`=0 one cycle later.
- **Mid-urgent reset and live value:** assert `rst_n`=0 during URGENT; all outputs return to reset values on the next edge. Separately, change the owner's `src_value` mid-dwell; `value` follows exactly 1 cycle later.
